fft_sample_loader: RTL and testbench

Streaming front end for `fft_top`: accepts ADC samples through a valid/ready handshake and writes one full frame into the FFT input RAM banks. It generates the per-bank write enables, a shared write address and the write data. It issues a one-cycle start pulse to the FFT when the frame is complete, then waits for the FFT ready flag before loading the next frame. It sits between the ADC capture logic and the `iWE_n` / `iADDR_WR_n` / `iDATA` / `iSTART` / `oRDY` ports of `fft_top`.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_bank_addr_gen.sv | 36 +++
 rtl/fft_sample_loader.sv | 148 ++++++++++++++
 tb/tb_fft_sample_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT front-end blocks: loader FSM states and sample order modes.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    LAUNCH   = 2'd2,
    WAIT_FFT = 2'd3
  } loader_state_t;

  localparam logic ORDER_BANK = 1'b0;
  localparam logic ORDER_INTL = 1'b1;

endpackage

// File: rtl/fft_bank_addr_gen.sv
// Maps a frame sample index to a one-hot bank select and a shared bank address,
// for either bank-major or interleaved placement.
module fft_bank_addr_gen
  import fft_pkg::*;
#(
  parameter int N_BANK     = 4,
  parameter int BANK_DEPTH = 512,
  parameter int ADDR_W     = $clog2(BANK_DEPTH),
  parameter int K_W        = $clog2(N_BANK * BANK_DEPTH)
) (
  input  logic [K_W-1:0]    k_i,
  input  logic              order_i,
  output logic [N_BANK-1:0] we_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int BANK_SH = $clog2(N_BANK);

  logic [K_W-1:0] bank_idx;

  // Both sizes are powers of two, so divide/modulo reduce to shifts and masks.
  always_comb begin
    if (order_i == ORDER_INTL) begin
      bank_idx = k_i & K_W'(N_BANK - 1);
      addr_o   = ADDR_W'(k_i >> BANK_SH);
    end else begin
      bank_idx = k_i >> ADDR_W;
      addr_o   = ADDR_W'(k_i);
    end
  end

  for (genvar gi = 0; gi < N_BANK; gi++) begin : g_we
    assign we_o[gi] = (bank_idx == K_W'(gi));
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Streams ADC samples into the FFT input RAM banks, one frame at a time, and
// launches the FFT once the frame is written.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int N_BANK     = 4,
  parameter int BANK_DEPTH = 512,
  parameter int ADDR_W     = $clog2(BANK_DEPTH)
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iARM,
  input  logic              iCONT,
  input  logic              iORDER,
  input  logic              iVALID,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oREADY,
  input  logic              iFFT_RDY,
  output logic [N_BANK-1:0] oWE,
  output logic [ADDR_W-1:0] oADDR_WR,
  output logic [DATA_W-1:0] oDATA,
  output logic              oSTART,
  output logic              oBUSY,
  output logic              oOVF,
  output logic [15:0]       oFRAME_CNT
);

  localparam int             FRAME  = N_BANK * BANK_DEPTH;
  localparam int             K_W    = $clog2(FRAME);
  localparam logic [K_W-1:0] K_LAST = K_W'(FRAME - 1);

  loader_state_t     state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              cont_q, cont_d;
  logic              order_q, order_d;
  logic              ovf_q, ovf_d;
  logic              start_q, start_d;
  logic              rdy_prev_q;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [N_BANK-1:0] we_q, we_d, gen_we;
  logic [ADDR_W-1:0] addr_q, addr_d, gen_addr;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept, rdy_rise, drop;

  fft_bank_addr_gen #(
    .N_BANK     (N_BANK),
    .BANK_DEPTH (BANK_DEPTH),
    .ADDR_W     (ADDR_W),
    .K_W        (K_W)
  ) u_addr_gen (
    .k_i     (k_q),
    .order_i (order_q),
    .we_o    (gen_we),
    .addr_o  (gen_addr)
  );

  // A re-arm in FILL restarts the frame, so a sample offered in that cycle is not written.
  assign accept   = (state_q == FILL) & iVALID & ~iARM;
  assign rdy_rise = iFFT_RDY & ~rdy_prev_q;
  assign drop     = cont_q & iVALID & ((state_q == LAUNCH) | (state_q == WAIT_FFT));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cont_d      = cont_q;
    order_d     = order_q;
    ovf_d       = ovf_q | drop;
    start_d     = (state_q == LAUNCH);
    frame_cnt_d = frame_cnt_q;
    we_d        = '0;
    addr_d      = addr_q;
    data_d      = data_q;

    if (state_q == LAUNCH) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (accept) begin
      we_d   = gen_we;
      addr_d = gen_addr;
      data_d = iDATA;
    end

    if (iARM) begin
      state_d = FILL;
      k_d     = '0;
      cont_d  = iCONT;
      order_d = iORDER;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        FILL: begin
          if (iVALID) begin
            if (k_q == K_LAST) state_d = LAUNCH;
            else               k_d     = k_q + K_W'(1);
          end
        end
        LAUNCH: state_d = WAIT_FFT;
        WAIT_FFT: begin
          if (rdy_rise) begin
            state_d = cont_q ? FILL : IDLE;
            k_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cont_q      <= 1'b0;
      order_q     <= ORDER_BANK;
      ovf_q       <= 1'b0;
      start_q     <= 1'b0;
      rdy_prev_q  <= 1'b0;
      frame_cnt_q <= '0;
      we_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cont_q      <= cont_d;
      order_q     <= order_d;
      ovf_q       <= ovf_d;
      start_q     <= start_d;
      rdy_prev_q  <= iFFT_RDY;
      frame_cnt_q <= frame_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign oREADY     = (state_q == FILL);
  assign oBUSY      = (state_q != IDLE);
  assign oWE        = we_q;
  assign oADDR_WR   = addr_q;
  assign oDATA      = data_q;
  assign oSTART     = start_q;
  assign oOVF       = ovf_q;
  assign oFRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: behavioural frame model compared every
// cycle, literal placement/timing pins, and a two-point parameter sweep.
module tb_fft_sample_loader;

  localparam int NB = 4;
  localparam int BD = 512;
  localparam int F  = NB * BD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0, cont = 1'b0, order = 1'b0, valid = 1'b0, fft_rdy = 1'b0;
  logic [15:0] din = '0;
  logic        ready, start, busy, ovf;
  logic [3:0]  we;
  logic [8:0]  addr;
  logic [15:0] dout, fcnt;

  always #5 clk = ~clk;

  fft_sample_loader #(.DATA_W(16), .N_BANK(NB), .BANK_DEPTH(BD)) u_dut (
    .iCLK(clk), .iRESET(rst_n), .iARM(arm), .iCONT(cont), .iORDER(order),
    .iVALID(valid), .iDATA(din), .oREADY(ready), .iFFT_RDY(fft_rdy),
    .oWE(we), .oADDR_WR(addr), .oDATA(dout), .oSTART(start), .oBUSY(busy),
    .oOVF(ovf), .oFRAME_CNT(fcnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (phase: 0 idle, 1 fill, 2 launch, 3 wait)
  int          m_phase, m_k, m_cnt, m_we;
  bit          m_cont, m_order, m_ovf, m_start, m_prev;
  int          m_addr;
  logic [15:0] m_data;

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_cnt = 0; m_we = 0; m_addr = 0; m_data = '0;
    m_cont = 0; m_order = 0; m_ovf = 0; m_start = 0; m_prev = 0;
  endtask

  task automatic model_step();
    bit rise;
    int bank;
    int a;
    rise    = fft_rdy && !m_prev;
    m_prev  = fft_rdy;
    m_start = (m_phase == 2);
    m_we    = 0;
    if (arm) begin
      if (m_phase == 2) m_cnt = (m_cnt + 1) % 65536;
      m_phase = 1; m_k = 0; m_cont = cont; m_order = order; m_ovf = 0;
    end else if (m_phase == 1) begin
      if (valid) begin
        if (!m_order) begin bank = m_k / BD; a = m_k % BD; end
        else          begin bank = m_k % NB; a = m_k / NB; end
        m_we = 1 << bank; m_addr = a; m_data = din;
        if (m_k == F - 1) m_phase = 2;
        else m_k++;
      end
    end else if (m_phase == 2) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (m_cont && valid) m_ovf = 1;
      m_phase = 3;
    end else if (m_phase == 3) begin
      if (m_cont && valid) m_ovf = 1;
      if (rise) begin m_phase = m_cont ? 1 : 0; m_k = 0; end
    end
  endtask

  // ---------------- per-cycle compare and observation log
  int  cyc = 0;
  int  start_count = 0, start_cyc = 0;
  int  obs_we[F], obs_addr[F], obs_cyc[F];
  bit  catch_first = 0;
  int  first_we = -1, first_addr = -1;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("ready", ready, m_phase == 1);
    chk("busy", busy, m_phase != 0);
    chk("we", we, m_we);
    chk("addr", addr, m_addr);
    chk("data", dout, m_data);
    chk("start", start, m_start);
    chk("ovf", ovf, m_ovf);
    chk("frame_cnt", fcnt, m_cnt);
    if (we != 0 && dout < F) begin
      obs_we[dout] = we; obs_addr[dout] = addr; obs_cyc[dout] = cyc;
    end
    if (catch_first && we != 0) begin
      first_we = we; first_addr = addr; catch_first = 0;
    end
    if (start) begin start_count++; start_cyc = cyc; end
  end

  // ---------------- stimulus helpers
  task automatic arm_pulse(input bit c, input bit o);
    @(negedge clk);
    arm = 1'b1; cont = c; order = o; valid = 1'b0;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic feed(input int n, input int pct);
    int sent = 0;
    int guard = 0;
    bit acc = 0;
    while (guard < 20000) begin
      if (acc) sent++;
      if (sent >= n) break;
      valid = ($urandom_range(99) < pct);
      din   = 16'(sent);
      acc   = valid && ready;
      guard++;
      @(negedge clk);
    end
    valid = 1'b0;
    if (guard >= 20000) chk("feed_timeout", sent, n);
  endtask

  task automatic wait_start(input int bound);
    bit found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (start) found = 1;
    end
    chk("start_seen", found, 1);
  endtask

  // ---------------- parameter sweep instances
  logic        s_arm = 1'b0, s_order = 1'b0, s_valid = 1'b0;
  logic [15:0] s_din = '0;
  int          sw_starts[2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_sw
    localparam int SN = (gi == 0) ? 1 : 8;
    localparam int SD = (gi == 0) ? 64 : 128;
    localparam int SF = SN * SD;
    localparam int SA = $clog2(SD);
    logic          s_ready, s_start, s_busy, s_ovf;
    logic [SN-1:0] s_we;
    logic [SA-1:0] s_addr;
    logic [15:0]   s_dout, s_fcnt;
    int            wcount = 0;

    fft_sample_loader #(.DATA_W(16), .N_BANK(SN), .BANK_DEPTH(SD)) u_sw (
      .iCLK(clk), .iRESET(rst_n), .iARM(s_arm), .iCONT(1'b0), .iORDER(s_order),
      .iVALID(s_valid), .iDATA(s_din), .oREADY(s_ready), .iFFT_RDY(1'b0),
      .oWE(s_we), .oADDR_WR(s_addr), .oDATA(s_dout), .oSTART(s_start), .oBUSY(s_busy),
      .oOVF(s_ovf), .oFRAME_CNT(s_fcnt)
    );

    always @(negedge clk) begin
      int k, bank, a;
      if (rst_n && s_we != 0) begin
        k = s_dout;
        if (!s_order) begin bank = k / SD; a = k % SD; end
        else          begin bank = k % SN; a = k / SN; end
        chk($sformatf("sw%0d_we", gi), s_we, longint'(1) << bank);
        chk($sformatf("sw%0d_addr", gi), s_addr, a);
        wcount++;
      end
      if (rst_n && s_start) begin
        chk($sformatf("sw%0d_frame_len", gi), wcount, SF);
        wcount = 0;
        sw_starts[gi]++;
      end
    end
  end

  // ---------------- main sequence
  initial begin
    int snap;
    bit found;
    sw_starts[0] = 0; sw_starts[1] = 0;

    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0); chk("rst_we", we, 0); chk("rst_addr", addr, 0);
    chk("rst_data", dout, 0); chk("rst_start", start, 0); chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0); chk("rst_fcnt", fcnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // bank-major single frame, ramp with random gaps
    arm_pulse(0, 0);
    feed(F, 70);
    wait_start(10);
    chk("bm_s600_we", obs_we[600], 4'b0010);
    chk("bm_s600_addr", obs_addr[600], 88);
    chk("bm_launch_gap", start_cyc - obs_cyc[F-1], 1);
    chk("bm_fcnt", fcnt, 1);
    repeat (5) @(negedge clk);
    chk("bm_waiting", busy, 1);
    fft_rdy = 1'b1;
    @(negedge clk);
    chk("bm_idle_after_rdy", busy, 0);
    fft_rdy = 1'b0;

    // interleaved single frame
    arm_pulse(0, 1);
    feed(F, 90);
    wait_start(10);
    chk("il_s5_we", obs_we[5], 4'b0010);
    chk("il_s5_addr", obs_addr[5], 1);
    chk("il_s2047_we", obs_we[2047], 4'b1000);
    chk("il_s2047_addr", obs_addr[2047], 511);
    @(negedge clk); fft_rdy = 1'b1;
    @(negedge clk); fft_rdy = 1'b0;
    chk("il_idle", busy, 0);

    // continuous, valid held high through WAIT_FFT
    arm_pulse(1, 1'($urandom_range(1)));
    for (int i = 0; i < 2200; i++) begin
      valid = 1'b1; din = 16'($urandom);
      @(negedge clk);
    end
    chk("ct_ovf", ovf, 1);
    chk("ct_fcnt1", fcnt, 3);
    fft_rdy = 1'b1; din = 16'($urandom);
    @(negedge clk);
    chk("ct_refill_ready", ready, 1);
    fft_rdy = 1'b0;
    found = 0;
    for (int i = 0; i < 2300 && !found; i++) begin
      din = 16'($urandom);
      @(negedge clk);
      if (start) found = 1;
    end
    chk("ct_second_start", found, 1);
    chk("ct_fcnt2", fcnt, 4);
    chk("ct_ovf_sticky", ovf, 1);
    valid = 1'b0;

    // FFT ready already high through LAUNCH is not an edge
    fft_rdy = 1'b1;
    arm_pulse(0, 0);
    feed(F, 100);
    wait_start(10);
    repeat (20) @(negedge clk);
    chk("hi_no_exit", busy, 1);
    fft_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("hi_low_still_wait", busy, 1);
    fft_rdy = 1'b1;
    @(negedge clk);
    chk("hi_exit_on_rise", busy, 0);
    fft_rdy = 1'b0;

    // re-arm mid-frame at k=1000
    arm_pulse(0, 1'($urandom_range(1)));
    feed(1000, 80);
    @(negedge clk);
    arm = 1'b1; cont = 1'b0; order = 1'b0; valid = 1'b0; catch_first = 1;
    @(negedge clk);
    arm = 1'b0;
    feed(1, 100);
    repeat (2) @(negedge clk);
    chk("rearm_we", first_we, 4'b0001);
    chk("rearm_addr", first_addr, 0);
    chk("rearm_fcnt", fcnt, 5);

    // asynchronous reset at k=300
    feed(299, 100);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", ready, 0); chk("ar_we", we, 0); chk("ar_addr", addr, 0);
    chk("ar_data", dout, 0); chk("ar_start", start, 0); chk("ar_busy", busy, 0);
    chk("ar_ovf", ovf, 0); chk("ar_fcnt", fcnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap = start_count;
    for (int i = 0; i < 100; i++) begin
      valid = 1'($urandom_range(1)); din = 16'($urandom); fft_rdy = 1'($urandom_range(1));
      @(negedge clk);
    end
    valid = 1'b0; fft_rdy = 1'b0;
    chk("ar_no_start", start_count - snap, 0);
    chk("ar_idle", busy, 0);

    // parameter sweep: bank-major then interleaved on both sweep instances
    for (int o = 0; o < 2; o++) begin
      @(negedge clk);
      s_arm = 1'b1; s_order = o[0]; s_valid = 1'b0;
      @(negedge clk);
      s_arm = 1'b0;
      for (int i = 0; i < 1100; i++) begin
        s_valid = 1'b1; s_din = 16'(i);
        @(negedge clk);
      end
      s_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("sw0_frames", sw_starts[0], 2);
    chk("sw1_frames", sw_starts[1], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
